axis_frame_buffer: RTL and testbench

AXIS_FRAME_BUFFER -- requirements
Module: axis_frame_buffer

---
 rtl/axis_buf_pkg.sv | 16 +
 rtl/axis_fifo_core.sv | 70 +++++++
 rtl/axis_frame_buffer.sv | 96 +++++++++
 tb/tb_axis_frame_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_buf_pkg.sv
// rtl/axis_buf_pkg.sv - shared encodings and helpers for the AXI-Stream frame buffer
package axis_buf_pkg;

    localparam int TLAST_MODE_GEN  = 0;
    localparam int TLAST_MODE_PASS = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_fifo_core.sv
// rtl/axis_fifo_core.sv - first-word fall-through circular buffer with occupancy count
module axis_fifo_core
    import axis_buf_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic [clog2(DEPTH):0] level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/axis_frame_buffer.sv
// rtl/axis_frame_buffer.sv - buffered AXI-Stream pass-through with frame tlast and tx_done
module axis_frame_buffer
    import axis_buf_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    parameter int FRAME_LEN            = 256,
    parameter int TLAST_MODE           = 0
) (
    input  logic                              axis_aclk,
    input  logic                              axis_aresetn,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_tstrb,
    input  logic                              S_AXIS_tlast,
    input  logic                              S_AXIS_tvalid,
    output logic                              S_AXIS_tready,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_tstrb,
    output logic                              M_AXIS_tlast,
    output logic                              M_AXIS_tvalid,
    input  logic                              M_AXIS_tready,
    output logic                              tx_done,
    output logic [clog2(FIFO_DEPTH):0]        fifo_level
);

    localparam int DW  = C_S_AXIS_TDATA_WIDTH;
    localparam int SW  = DW / 8;
    localparam int EW  = DW + SW + 1;
    localparam int FCW = (FRAME_LEN > 1) ? clog2(FRAME_LEN) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);

    logic           in_ready_q;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           tx_done_q, tx_done_d;
    logic           push, pop, full, empty, head_last;
    logic [EW-1:0]  head;

    axis_fifo_core #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (axis_aclk),
        .rst_ni  (axis_aresetn),
        .push_i  (push),
        .wdata_i ({S_AXIS_tdata, S_AXIS_tstrb, S_AXIS_tlast}),
        .pop_i   (pop),
        .rdata_o (head),
        .level_o (fifo_level),
        .full_o  (full),
        .empty_o (empty)
    );

    // in_ready_q keeps tready low during reset and until the first edge after release
    assign S_AXIS_tready = in_ready_q && !full;
    assign M_AXIS_tvalid = !empty;
    assign push          = S_AXIS_tvalid && S_AXIS_tready;
    assign pop           = M_AXIS_tvalid && M_AXIS_tready;
    assign M_AXIS_tdata  = head[EW-1:SW+1];
    assign M_AXIS_tstrb  = head[SW:1];
    assign head_last     = head[0];
    assign tx_done       = tx_done_q;

    always_comb begin
        if (TLAST_MODE == TLAST_MODE_GEN) begin
            M_AXIS_tlast = M_AXIS_tvalid && (frame_cnt_q == FRAME_LAST);
        end else begin
            M_AXIS_tlast = M_AXIS_tvalid && head_last;
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        tx_done_d   = pop && M_AXIS_tlast;
        if (pop) begin
            if ((frame_cnt_q == FRAME_LAST) ||
                ((TLAST_MODE == TLAST_MODE_PASS) && head_last)) begin
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            in_ready_q  <= 1'b0;
            frame_cnt_q <= '0;
            tx_done_q   <= 1'b0;
        end else begin
            in_ready_q  <= 1'b1;
            frame_cnt_q <= frame_cnt_d;
            tx_done_q   <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_axis_frame_buffer.sv
// tb/tb_axis_frame_buffer.sv - randomized self-checking bench for axis_frame_buffer
module tb_axis_frame_buffer;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DUT A: defaults (depth 16, frame 256, generated tlast)
    logic        rstn_a;
    logic [31:0] a_sd, a_md;
    logic [3:0]  a_ss, a_ms;
    logic        a_sl, a_sv, a_sr, a_ml, a_mv, a_mr, a_done;
    logic [4:0]  a_lvl;
    // DUT B: passed-through tlast
    logic        rstn_b;
    logic [31:0] b_sd, b_md;
    logic [3:0]  b_ss, b_ms;
    logic        b_sl, b_sv, b_sr, b_ml, b_mv, b_mr, b_done;
    logic [4:0]  b_lvl;
    // DUT C: one-beat frames, depth 4
    logic        rstn_c;
    logic [31:0] c_sd, c_md;
    logic [3:0]  c_ss, c_ms;
    logic        c_sl, c_sv, c_sr, c_ml, c_mv, c_mr, c_done;
    logic [2:0]  c_lvl;

    axis_frame_buffer u_a (
        .axis_aclk(clk), .axis_aresetn(rstn_a),
        .S_AXIS_tdata(a_sd), .S_AXIS_tstrb(a_ss), .S_AXIS_tlast(a_sl),
        .S_AXIS_tvalid(a_sv), .S_AXIS_tready(a_sr),
        .M_AXIS_tdata(a_md), .M_AXIS_tstrb(a_ms), .M_AXIS_tlast(a_ml),
        .M_AXIS_tvalid(a_mv), .M_AXIS_tready(a_mr),
        .tx_done(a_done), .fifo_level(a_lvl)
    );

    axis_frame_buffer #(.TLAST_MODE(1)) u_b (
        .axis_aclk(clk), .axis_aresetn(rstn_b),
        .S_AXIS_tdata(b_sd), .S_AXIS_tstrb(b_ss), .S_AXIS_tlast(b_sl),
        .S_AXIS_tvalid(b_sv), .S_AXIS_tready(b_sr),
        .M_AXIS_tdata(b_md), .M_AXIS_tstrb(b_ms), .M_AXIS_tlast(b_ml),
        .M_AXIS_tvalid(b_mv), .M_AXIS_tready(b_mr),
        .tx_done(b_done), .fifo_level(b_lvl)
    );

    axis_frame_buffer #(.FIFO_DEPTH(4), .FRAME_LEN(1)) u_c (
        .axis_aclk(clk), .axis_aresetn(rstn_c),
        .S_AXIS_tdata(c_sd), .S_AXIS_tstrb(c_ss), .S_AXIS_tlast(c_sl),
        .S_AXIS_tvalid(c_sv), .S_AXIS_tready(c_sr),
        .M_AXIS_tdata(c_md), .M_AXIS_tstrb(c_ms), .M_AXIS_tlast(c_ml),
        .M_AXIS_tvalid(c_mv), .M_AXIS_tready(c_mr),
        .tx_done(c_done), .fifo_level(c_lvl)
    );

    // Reference models: queue contents, beats delivered since reset, pending tx_done
    beat_t qa[$], qb[$], qc[$];
    int    outs_a = 0, outs_b = 0, outs_c = 0;
    bit    da = 0, db = 0, dc = 0;
    bit    ra = 0, rb = 0, rc = 0;

    function automatic bit ea_last();
        return (qa.size() != 0) && ((outs_a % 256) == 255);
    endfunction

    task automatic model_a(input bit v, input beat_t b, input bit r);
        beat_t tmp;
        bit pv, pr, pl;
        pv = (qa.size() != 0);
        pr = ra && (qa.size() != 16);
        pl = ea_last();
        da = pv && r && pl;
        if (pv && r) begin tmp = qa.pop_front(); outs_a++; end
        if (v && pr) qa.push_back(b);
        ra = 1'b1;
    endtask

    task automatic model_b(input bit v, input beat_t b, input bit r);
        beat_t tmp;
        bit pv, pr;
        pv = (qb.size() != 0);
        pr = rb && (qb.size() != 16);
        db = pv && r && qb[0].l;
        if (pv && r) begin tmp = qb.pop_front(); outs_b++; end
        if (v && pr) qb.push_back(b);
        rb = 1'b1;
    endtask

    task automatic model_c(input bit v, input beat_t b, input bit r);
        beat_t tmp;
        bit pv, pr;
        pv = (qc.size() != 0);
        pr = rc && (qc.size() != 4);
        dc = pv && r;
        if (pv && r) begin tmp = qc.pop_front(); outs_c++; end
        if (v && pr) qc.push_back(b);
        rc = 1'b1;
    endtask

    task automatic drive_a(input bit v, input beat_t b, input bit r);
        a_sv = v; a_sd = b.d; a_ss = b.s; a_sl = b.l; a_mr = r;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        a_sv = 1'b1; a_sd = 32'h1234_5678;
        @(negedge clk);
        total++; if (a_sr !== 1'b0) begin bad++; $display("FAIL rst_s_tready got=%b exp=0", a_sr); end
        total++; if (a_mv !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid got=%b exp=0", a_mv); end
        total++; if (a_ml !== 1'b0) begin bad++; $display("FAIL rst_m_tlast got=%b exp=0", a_ml); end
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rst_tx_done got=%b exp=0", a_done); end
        total++; if (a_lvl !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", a_lvl); end
        total++; if (b_sr !== 1'b0 || c_sr !== 1'b0) begin bad++; $display("FAIL rst_bc_tready got=%b%b exp=00", b_sr, c_sr); end
        a_sv = 1'b0;
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
        #1;
        total++; if (a_sr !== 1'b0) begin bad++; $display("FAIL release_tready_early got=%b exp=0", a_sr); end
        model_a(1'b0, '0, 1'b0);
        rb = 1'b1; rc = 1'b1;
        @(negedge clk);
        total++; if (a_sr !== 1'b1) begin bad++; $display("FAIL release_tready got=%b exp=1", a_sr); end
        total++; if (b_sr !== 1'b1 || c_sr !== 1'b1) begin bad++; $display("FAIL release_bc_tready got=%b%b exp=11", b_sr, c_sr); end
    endtask

    task automatic test_continuous();
        beat_t b;
        int lidx[$];
        int dones = 0;
        b = '{d: 32'hABCDEF01, s: 4'hF, l: 1'b0};
        for (int i = 0; i < 530; i++) begin
            @(negedge clk);
            drive_a(1'b1, b, 1'b1);
            total++; if (a_mv !== (qa.size() != 0)) begin bad++; $display("FAIL cont_tvalid i=%0d got=%b exp=%b", i, a_mv, qa.size() != 0); end
            if (qa.size() != 0) begin
                total++; if (a_md !== qa[0].d) begin bad++; $display("FAIL cont_tdata i=%0d got=%h exp=%h", i, a_md, qa[0].d); end
            end
            total++; if (a_ml !== ea_last()) begin bad++; $display("FAIL cont_tlast i=%0d got=%b exp=%b", i, a_ml, ea_last()); end
            total++; if (a_done !== da) begin bad++; $display("FAIL cont_tx_done i=%0d got=%b exp=%b", i, a_done, da); end
            if (a_ml === 1'b1 && a_mv === 1'b1) lidx.push_back(outs_a + 1);
            if (a_done === 1'b1) dones++;
            model_a(1'b1, b, 1'b1);
        end
        total++; if (lidx.size() != 2) begin bad++; $display("FAIL cont_tlast_count got=%0d exp=2", lidx.size()); end
        else begin
            total++; if (lidx[0] != 256 || lidx[1] != 512) begin bad++; $display("FAIL cont_tlast_beats got=%0d,%0d exp=256,512", lidx[0], lidx[1]); end
        end
        total++; if (dones != 2) begin bad++; $display("FAIL cont_tx_done_count got=%0d exp=2", dones); end
    endtask

    task automatic test_backpressure();
        beat_t b;
        int cyc;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            b = '{d: $urandom, s: 4'($urandom), l: 1'b0};
            drive_a(1'b1, b, 1'b0);
            total++; if (a_sr !== (qa.size() != 16)) begin bad++; $display("FAIL bp_tready i=%0d got=%b exp=%b", i, a_sr, qa.size() != 16); end
            total++; if (a_lvl !== 5'(qa.size())) begin bad++; $display("FAIL bp_level i=%0d got=%0d exp=%0d", i, a_lvl, qa.size()); end
            if (qa.size() != 0) begin
                total++; if ({a_md, a_ms} !== {qa[0].d, qa[0].s}) begin bad++; $display("FAIL bp_hold i=%0d got=%h exp=%h", i, a_md, qa[0].d); end
            end
            model_a(1'b1, b, 1'b0);
        end
        total++; if (a_lvl !== 5'd16 || a_sr !== 1'b0) begin bad++; $display("FAIL bp_full level=%0d tready=%b exp=16,0", a_lvl, a_sr); end
        cyc = 0;
        while ((cyc < 30 || qa.size() != 0) && cyc < 100) begin
            @(negedge clk);
            b = '{d: $urandom, s: 4'($urandom), l: 1'b0};
            drive_a(cyc < 30, b, 1'b1);
            total++; if (a_mv !== (qa.size() != 0)) begin bad++; $display("FAIL bp_drain_tvalid c=%0d got=%b exp=%b", cyc, a_mv, qa.size() != 0); end
            if (qa.size() != 0) begin
                total++; if ({a_md, a_ms} !== {qa[0].d, qa[0].s}) begin bad++; $display("FAIL bp_drain_data c=%0d got=%h exp=%h", cyc, a_md, qa[0].d); end
            end
            total++; if (a_ml !== ea_last()) begin bad++; $display("FAIL bp_drain_tlast c=%0d got=%b exp=%b", cyc, a_ml, ea_last()); end
            model_a(cyc < 30, b, 1'b1);
            cyc++;
        end
        @(negedge clk);
        drive_a(1'b0, '0, 1'b1);
        total++; if (a_lvl !== 5'd0 || qa.size() != 0) begin bad++; $display("FAIL bp_drained level=%0d model=%0d exp=0", a_lvl, qa.size()); end
        model_a(1'b0, '0, 1'b1);
    endtask

    task automatic test_source_gap();
        beat_t b;
        bit v;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            v = !(i >= 10 && i < 15);
            b = '{d: $urandom, s: 4'($urandom), l: 1'b0};
            drive_a(v, b, 1'b1);
            total++; if (a_mv !== (qa.size() != 0)) begin bad++; $display("FAIL gap_tvalid i=%0d got=%b exp=%b", i, a_mv, qa.size() != 0); end
            total++; if (a_ml !== ea_last()) begin bad++; $display("FAIL gap_tlast i=%0d got=%b exp=%b", i, a_ml, ea_last()); end
            total++; if (a_done !== da) begin bad++; $display("FAIL gap_tx_done i=%0d got=%b exp=%b", i, a_done, da); end
            if (i == 14) begin
                total++; if (a_mv !== 1'b0) begin bad++; $display("FAIL gap_drained got=%b exp=0", a_mv); end
            end
            model_a(v, b, 1'b1);
        end
    endtask

    task automatic test_reset_midstream();
        beat_t b;
        int lidx[$];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_a(1'b0, '0, 1'b1);
            model_a(1'b0, '0, 1'b1);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            b = '{d: $urandom, s: 4'($urandom), l: 1'b0};
            drive_a(1'b1, b, 1'b0);
            model_a(1'b1, b, 1'b0);
        end
        @(negedge clk);
        drive_a(1'b0, '0, 1'b0);
        total++; if (a_lvl !== 5'd7) begin bad++; $display("FAIL mid_prefill got=%0d exp=7", a_lvl); end
        #2 rstn_a = 1'b0;
        #1;
        total++; if (a_lvl !== 5'd0) begin bad++; $display("FAIL mid_rst_level got=%0d exp=0", a_lvl); end
        total++; if (a_mv !== 1'b0) begin bad++; $display("FAIL mid_rst_tvalid got=%b exp=0", a_mv); end
        qa.delete(); outs_a = 0; da = 1'b0; ra = 1'b0;
        @(negedge clk);
        rstn_a = 1'b1;
        model_a(1'b0, '0, 1'b0);
        b = '{d: 32'h0, s: 4'hF, l: 1'b0};
        for (int i = 0; i < 262; i++) begin
            @(negedge clk);
            b.d = $urandom;
            drive_a(1'b1, b, 1'b1);
            if (qa.size() != 0) begin
                total++; if (a_md !== qa[0].d) begin bad++; $display("FAIL mid_tdata i=%0d got=%h exp=%h", i, a_md, qa[0].d); end
            end
            total++; if (a_ml !== ea_last()) begin bad++; $display("FAIL mid_tlast i=%0d got=%b exp=%b", i, a_ml, ea_last()); end
            total++; if (a_done !== da) begin bad++; $display("FAIL mid_tx_done i=%0d got=%b exp=%b", i, a_done, da); end
            if (a_ml === 1'b1 && a_mv === 1'b1) lidx.push_back(outs_a + 1);
            model_a(1'b1, b, 1'b1);
        end
        total++; if (lidx.size() != 1 || lidx[0] != 256) begin bad++; $display("FAIL mid_first_tlast count=%0d exp first beat 256", lidx.size()); end
        @(negedge clk);
        drive_a(1'b0, '0, 1'b0);
        model_a(1'b0, '0, 1'b0);
    endtask

    task automatic test_tlast_pass();
        beat_t b;
        int k = 1, cyc = 0, dones = 0;
        int lidx[$];
        bit v, r;
        while ((outs_b < 12 || cyc < 4) && cyc < 300) begin
            @(negedge clk);
            v = (k <= 12);
            r = 1'($urandom);
            b = '{d: $urandom, s: 4'($urandom), l: (k == 3 || k == 10)};
            b_sv = v; b_sd = b.d; b_ss = b.s; b_sl = b.l; b_mr = r;
            total++; if (b_mv !== (qb.size() != 0)) begin bad++; $display("FAIL pass_tvalid c=%0d got=%b exp=%b", cyc, b_mv, qb.size() != 0); end
            if (qb.size() != 0) begin
                total++; if ({b_md, b_ms, b_ml} !== {qb[0].d, qb[0].s, qb[0].l}) begin bad++; $display("FAIL pass_head c=%0d got=%h/%b exp=%h/%b", cyc, b_md, b_ml, qb[0].d, qb[0].l); end
            end else begin
                total++; if (b_ml !== 1'b0) begin bad++; $display("FAIL pass_tlast_idle c=%0d got=%b exp=0", cyc, b_ml); end
            end
            total++; if (b_done !== db) begin bad++; $display("FAIL pass_tx_done c=%0d got=%b exp=%b", cyc, b_done, db); end
            if (b_ml === 1'b1 && b_mv === 1'b1 && r) lidx.push_back(outs_b + 1);
            if (b_done === 1'b1) dones++;
            if (v && rb && qb.size() != 16) k++;
            model_b(v, b, r);
            cyc++;
        end
        total++; if (outs_b != 12) begin bad++; $display("FAIL pass_timeout delivered=%0d exp=12", outs_b); end
        total++; if (lidx.size() != 2) begin bad++; $display("FAIL pass_tlast_count got=%0d exp=2", lidx.size()); end
        else begin
            total++; if (lidx[0] != 3 || lidx[1] != 10) begin bad++; $display("FAIL pass_tlast_beats got=%0d,%0d exp=3,10", lidx[0], lidx[1]); end
        end
        total++; if (dones != 2) begin bad++; $display("FAIL pass_tx_done_count got=%0d exp=2", dones); end
    endtask

    task automatic test_frame_len_one();
        beat_t b;
        bit v, r;
        int dones = 0;
        for (int i = 0; i < 301; i++) begin
            @(negedge clk);
            v = (i < 300) && ($urandom_range(3, 0) != 0);
            r = (i == 300) || ($urandom_range(2, 0) != 0);
            b = '{d: $urandom, s: 4'($urandom), l: 1'($urandom)};
            c_sv = v; c_sd = b.d; c_ss = b.s; c_sl = b.l; c_mr = r;
            total++; if (c_mv !== (qc.size() != 0)) begin bad++; $display("FAIL one_tvalid i=%0d got=%b exp=%b", i, c_mv, qc.size() != 0); end
            total++; if (c_ml !== (qc.size() != 0)) begin bad++; $display("FAIL one_tlast i=%0d got=%b exp=%b", i, c_ml, qc.size() != 0); end
            total++; if (c_sr !== (qc.size() != 4)) begin bad++; $display("FAIL one_tready i=%0d got=%b exp=%b", i, c_sr, qc.size() != 4); end
            total++; if (c_lvl !== 3'(qc.size())) begin bad++; $display("FAIL one_level i=%0d got=%0d exp=%0d", i, c_lvl, qc.size()); end
            total++; if (c_done !== dc) begin bad++; $display("FAIL one_tx_done i=%0d got=%b exp=%b", i, c_done, dc); end
            if (qc.size() != 0) begin
                total++; if ({c_md, c_ms} !== {qc[0].d, qc[0].s}) begin bad++; $display("FAIL one_tdata i=%0d got=%h exp=%h", i, c_md, qc[0].d); end
            end
            if (c_done === 1'b1) dones++;
            model_c(v, b, r);
        end
        @(negedge clk);
        c_sv = 1'b0; c_mr = 1'b0;
        if (c_done === 1'b1) dones++;
        total++; if (dones != outs_c) begin bad++; $display("FAIL one_tx_done_count got=%0d exp=%0d", dones, outs_c); end
    endtask

    initial begin
        rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
        a_sv = 1'b0; a_sd = '0; a_ss = '0; a_sl = 1'b0; a_mr = 1'b0;
        b_sv = 1'b0; b_sd = '0; b_ss = '0; b_sl = 1'b0; b_mr = 1'b0;
        c_sv = 1'b0; c_sd = '0; c_ss = '0; c_sl = 1'b0; c_mr = 1'b0;
        test_reset();
        test_continuous();
        test_backpressure();
        test_source_gap();
        test_reset_midstream();
        test_tlast_pass();
        test_frame_len_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
